// File: rtl/char_column_segment.sv
`default_nettype none
// ============================================================================
// Module   : char_column_segment
// Purpose  : Splits a located licence plate into character columns. During
//            the frame it builds a per-column ink projection inside the plate
//            rectangle. After the frame ends it scans that projection for ink
//            runs and publishes the character boundaries and centres.
// Revision : 1.0 - initial release
// ============================================================================
module char_column_segment #(
    parameter int COL_TH = 2,
    parameter int MIN_W  = 3,
    parameter int H_ACT  = 480
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_vs,
    input  logic        i_de,
    input  logic        i_bit,
    input  logic [11:0] x,
    input  logic [11:0] y,
    input  logic [11:0] edge_left,
    input  logic [11:0] edge_right,
    input  logic [11:0] edge_up,
    input  logic [11:0] edge_down,
    output logic [11:0] Partition_line1,
    output logic [11:0] Partition_line2,
    output logic [11:0] Partition_line3,
    output logic [11:0] Partition_line4,
    output logic [11:0] Partition_line5,
    output logic [11:0] Partition_line6,
    output logic [11:0] char1_middle,
    output logic [11:0] char2_middle,
    output logic [11:0] char3_middle,
    output logic [11:0] char4_middle,
    output logic [11:0] char5_middle,
    output logic [3:0]  seg_cnt,
    output logic        seg_valid,
    output logic        seg_err
);

    localparam int         AW      = (H_ACT > 1) ? $clog2(H_ACT) : 1;
    localparam int         NRUN    = 5;
    localparam logic [8:0] CNT_MAX = 9'd511;
    localparam logic [8:0] TH9     = 9'(COL_TH);

    typedef enum logic [1:0] {
        ACCUM = 2'd0,
        SCAN  = 2'd1,
        LATCH = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [AW-1:0]   col_q, col_d;
    logic            vs_q;

    // Pixel pipeline stage and the column projection RAM
    logic            pix_vld_q;
    logic [AW-1:0]   pix_addr_q;
    logic [8:0]      colcnt_q [H_ACT];

    // Run tracking during the scan
    logic            in_run_q, in_run_d;
    logic [11:0]     start_q, start_d;
    logic [3:0]      run_cnt_q;
    logic [11:0]     s_q [NRUN];
    logic [11:0]     e_q [NRUN];

    // Registered outputs
    logic [11:0]     line_q [NRUN+1];
    logic [11:0]     mid_q  [NRUN];
    logic [3:0]      seg_cnt_q;
    logic            seg_valid_q;
    logic            seg_err_q;

    // Combinational helpers
    logic            w_vs_rise;
    logic            w_in_plate;
    logic            w_pix_ok;
    logic [8:0]      w_acc_rd;
    logic [8:0]      w_scan_rd;
    logic [11:0]     w_col12;
    logic            w_in_rect;
    logic            w_ink;
    logic            w_last;
    logic            w_end_here;
    logic            w_close;
    logic [11:0]     w_end;
    logic [11:0]     w_run_s;
    logic [12:0]     w_width;
    logic            w_keep;
    logic [11:0]     w_mid [NRUN];
    logic [11:0]     w_gap [NRUN-1];

    assign w_vs_rise  = i_vs & ~vs_q;
    assign w_in_plate = (x >= edge_left) && (x <= edge_right) &&
                        (y >= edge_up)   && (y <= edge_down);
    // Pixels are only taken while accumulating; the cycle of the frame-end
    // edge is excluded so nothing lands in the RAM once the scan begins.
    assign w_pix_ok   = i_de && i_bit && w_in_plate && (x < 12'(H_ACT)) &&
                        (state_q == ACCUM) && !w_vs_rise;

    assign w_acc_rd   = colcnt_q[pix_addr_q];
    assign w_scan_rd  = colcnt_q[col_q];
    assign w_col12    = 12'(col_q);
    assign w_in_rect  = (w_col12 >= edge_left) && (w_col12 <= edge_right);
    assign w_ink      = w_in_rect && (w_scan_rd >= TH9);
    assign w_last     = (col_q == AW'(H_ACT - 1));
    assign w_end_here = (w_col12 == edge_right) || w_last;

    // State register, frame-sync edge detector and scan column counter
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ACCUM;
            col_q   <= '0;
            vs_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            col_q   <= col_d;
            vs_q    <= i_vs;
        end
    end

    // Next-state logic: accumulate until frame end, scan every column, latch
    always_comb begin
        state_d = state_q;
        col_d   = col_q;
        case (state_q)
            ACCUM: begin
                col_d = '0;
                if (w_vs_rise) begin
                    state_d = SCAN;
                end
            end
            SCAN: begin
                if (w_last) begin
                    state_d = LATCH;
                    col_d   = '0;
                end else begin
                    col_d = col_q + AW'(1);
                end
            end
            LATCH: begin
                state_d = ACCUM;
            end
            default: begin
                state_d = ACCUM;
                col_d   = '0;
            end
        endcase
    end

    // Pixel pipeline: capture the column address, increment on the next cycle
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pix_vld_q  <= 1'b0;
            pix_addr_q <= '0;
        end else begin
            pix_vld_q  <= w_pix_ok;
            pix_addr_q <= x[AW-1:0];
        end
    end

    // Projection RAM: saturating increment while accumulating, clear on scan
    always_ff @(posedge clk) begin
        if (state_q == SCAN) begin
            colcnt_q[col_q] <= '0;
        end else if (pix_vld_q && (w_acc_rd != CNT_MAX)) begin
            colcnt_q[pix_addr_q] <= w_acc_rd + 9'd1;
        end
    end

    // Run boundary detection for the current scan column
    always_comb begin
        in_run_d = in_run_q;
        start_d  = start_q;
        w_close  = 1'b0;
        w_end    = w_col12;
        if (w_ink) begin
            if (!in_run_q) begin
                start_d = w_col12;
            end
            if (w_end_here) begin
                w_close  = 1'b1;
                in_run_d = 1'b0;
            end else begin
                in_run_d = 1'b1;
            end
        end else if (in_run_q) begin
            w_close  = 1'b1;
            w_end    = w_col12 - 12'd1;
            in_run_d = 1'b0;
        end
        w_run_s = in_run_q ? start_q : w_col12;
        w_width = {1'b0, w_end} - {1'b0, w_run_s} + 13'd1;
        w_keep  = w_close && (w_width >= 13'(MIN_W));
    end

    // Run bookkeeping: cleared at frame end, first five kept runs stored
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            in_run_q  <= 1'b0;
            start_q   <= '0;
            run_cnt_q <= '0;
            for (int k = 0; k < NRUN; k++) begin
                s_q[k] <= '0;
                e_q[k] <= '0;
            end
        end else if ((state_q == ACCUM) && w_vs_rise) begin
            in_run_q  <= 1'b0;
            run_cnt_q <= '0;
        end else if (state_q == SCAN) begin
            in_run_q <= in_run_d;
            start_q  <= start_d;
            if (w_keep) begin
                if (run_cnt_q < 4'd5) begin
                    s_q[run_cnt_q[2:0]] <= w_run_s;
                    e_q[run_cnt_q[2:0]] <= w_end;
                end
                if (run_cnt_q != 4'hF) begin
                    run_cnt_q <= run_cnt_q + 4'd1;
                end
            end
        end
    end

    // Centre and gap midpoints, summed at 13 bits before halving
    for (genvar k = 0; k < NRUN; k++) begin : g_mid
        assign w_mid[k] = 12'(({1'b0, s_q[k]} + {1'b0, e_q[k]}) >> 1);
    end
    for (genvar k = 0; k < NRUN - 1; k++) begin : g_gap
        assign w_gap[k] = 12'(({1'b0, e_q[k]} + {1'b0, s_q[k+1]}) >> 1);
    end

    // Output registers: only the latch cycle may change them
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            seg_cnt_q   <= '0;
            seg_valid_q <= 1'b0;
            seg_err_q   <= 1'b0;
            for (int k = 0; k <= NRUN; k++) begin
                line_q[k] <= '0;
            end
            for (int k = 0; k < NRUN; k++) begin
                mid_q[k] <= '0;
            end
        end else begin
            seg_valid_q <= 1'b0;
            if (state_q == LATCH) begin
                seg_cnt_q <= run_cnt_q;
                if (run_cnt_q == 4'd5) begin
                    seg_valid_q  <= 1'b1;
                    seg_err_q    <= 1'b0;
                    line_q[0]    <= s_q[0];
                    line_q[NRUN] <= e_q[NRUN-1];
                    for (int k = 0; k < NRUN - 1; k++) begin
                        line_q[k+1] <= w_gap[k];
                    end
                    for (int k = 0; k < NRUN; k++) begin
                        mid_q[k] <= w_mid[k];
                    end
                end else begin
                    seg_err_q <= 1'b1;
                end
            end
        end
    end

    assign Partition_line1 = line_q[0];
    assign Partition_line2 = line_q[1];
    assign Partition_line3 = line_q[2];
    assign Partition_line4 = line_q[3];
    assign Partition_line5 = line_q[4];
    assign Partition_line6 = line_q[5];
    assign char1_middle    = mid_q[0];
    assign char2_middle    = mid_q[1];
    assign char3_middle    = mid_q[2];
    assign char4_middle    = mid_q[3];
    assign char5_middle    = mid_q[4];
    assign seg_cnt         = seg_cnt_q;
    assign seg_valid       = seg_valid_q;
    assign seg_err         = seg_err_q;

endmodule
`default_nettype wire

// File: tb/tb_char_column_segment.sv
`default_nettype none
// ============================================================================
// Module   : tb_char_column_segment
// Purpose  : Directed frame-level checks for char_column_segment.
// Revision : 1.0 - initial release
// ============================================================================
module tb_char_column_segment;

    logic        clk = 1'b0;
    logic        rst;
    logic        i_vs, i_de, i_bit;
    logic [11:0] x, y, edge_left, edge_right, edge_up, edge_down;
    logic [11:0] Partition_line1, Partition_line2, Partition_line3;
    logic [11:0] Partition_line4, Partition_line5, Partition_line6;
    logic [11:0] char1_middle, char2_middle, char3_middle, char4_middle, char5_middle;
    logic [3:0]  seg_cnt;
    logic        seg_valid, seg_err;

    int n_tests = 0;
    int n_fail  = 0;
    int valid_cnt = 0;

    logic [11:0] obs_all [11];
    logic [11:0] exp_all [11];

    typedef struct {
        int x0;
        int x1;
        int y0;
        int rows;
        bit de;
        bit colmajor;
    } bar_t;
    bar_t bars[$];

    always #5 clk = ~clk;

    char_column_segment #(.COL_TH(2), .MIN_W(3), .H_ACT(480)) dut (
        .clk(clk), .rst(rst), .i_vs(i_vs), .i_de(i_de), .i_bit(i_bit),
        .x(x), .y(y),
        .edge_left(edge_left), .edge_right(edge_right),
        .edge_up(edge_up), .edge_down(edge_down),
        .Partition_line1(Partition_line1), .Partition_line2(Partition_line2),
        .Partition_line3(Partition_line3), .Partition_line4(Partition_line4),
        .Partition_line5(Partition_line5), .Partition_line6(Partition_line6),
        .char1_middle(char1_middle), .char2_middle(char2_middle),
        .char3_middle(char3_middle), .char4_middle(char4_middle),
        .char5_middle(char5_middle),
        .seg_cnt(seg_cnt), .seg_valid(seg_valid), .seg_err(seg_err)
    );

    // Lines in slots 0..5, middles in slots 6..10
    always_comb begin
        obs_all[0]  = Partition_line1;
        obs_all[1]  = Partition_line2;
        obs_all[2]  = Partition_line3;
        obs_all[3]  = Partition_line4;
        obs_all[4]  = Partition_line5;
        obs_all[5]  = Partition_line6;
        obs_all[6]  = char1_middle;
        obs_all[7]  = char2_middle;
        obs_all[8]  = char3_middle;
        obs_all[9]  = char4_middle;
        obs_all[10] = char5_middle;
    end

    // Count valid pulses seen since the last frame started
    always @(negedge clk) begin
        if (seg_valid === 1'b1) valid_cnt++;
    end

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic put_pixel(input int xx, input int yy, input bit de);
        @(posedge clk);
        #1;
        i_de  = de;
        i_bit = 1'b1;
        x     = 12'(xx);
        y     = 12'(yy);
    endtask

    task automatic add_bar(input int x0, input int x1, input int y0, input int rows,
                           input bit de, input bit cm);
        bar_t b;
        b.x0 = x0; b.x1 = x1; b.y0 = y0; b.rows = rows; b.de = de; b.colmajor = cm;
        bars.push_back(b);
    endtask

    // Five 10-row bars (third drawn column-major) plus pixels that must be ignored
    task automatic add_base();
        add_bar(60,  80,  100, 10, 1'b1, 1'b0);
        add_bar(130, 150, 100, 10, 1'b1, 1'b0);
        add_bar(200, 220, 100, 10, 1'b1, 1'b1);
        add_bar(270, 290, 100, 10, 1'b1, 1'b0);
        add_bar(340, 360, 100, 10, 1'b1, 1'b0);
        add_bar(300, 310, 100, 5,  1'b0, 1'b0);
        add_bar(380, 390, 250, 5,  1'b1, 1'b0);
        add_bar(20,  30,  100, 5,  1'b1, 1'b0);
    endtask

    task automatic drive_bars();
        foreach (bars[i]) begin
            if (bars[i].colmajor) begin
                for (int c = bars[i].x0; c <= bars[i].x1; c++)
                    for (int r = 0; r < bars[i].rows; r++)
                        put_pixel(c, bars[i].y0 + r, bars[i].de);
            end else begin
                for (int r = 0; r < bars[i].rows; r++)
                    for (int c = bars[i].x0; c <= bars[i].x1; c++)
                        put_pixel(c, bars[i].y0 + r, bars[i].de);
            end
        end
        @(posedge clk);
        #1;
        i_de  = 1'b0;
        i_bit = 1'b0;
        x     = '0;
        y     = '0;
    endtask

    task automatic pulse_vs();
        idle(2);
        i_vs = 1'b1;
        idle(3);
        i_vs = 1'b0;
    endtask

    // Feed the queued bars, end the frame and wait past scan and latch
    task automatic run_frame();
        valid_cnt = 0;
        drive_bars();
        pulse_vs();
        idle(495);
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        idle(3);
        @(negedge clk);
        for (int k = 0; k < 11; k++) begin
            n_tests++;
            if (obs_all[k] !== 12'd0) begin
                n_fail++;
                $display("FAIL reset out%0d: got %0d expected 0", k, obs_all[k]);
            end
        end
        n_tests++;
        if ({seg_cnt, seg_valid, seg_err} !== 6'd0) begin
            n_fail++;
            $display("FAIL reset status: got cnt=%0d valid=%0b err=%0b expected all 0",
                     seg_cnt, seg_valid, seg_err);
        end
        idle(1);
        rst = 1'b0;
        idle(2);
        bars.delete();
        run_frame();
    endtask

    task automatic test_basic();
        bars.delete();
        add_base();
        run_frame();
        exp_all = '{12'd60, 12'd105, 12'd175, 12'd245, 12'd315, 12'd360,
                    12'd70, 12'd140, 12'd210, 12'd280, 12'd350};
        for (int k = 0; k < 11; k++) begin
            n_tests++;
            if (obs_all[k] !== exp_all[k]) begin
                n_fail++;
                $display("FAIL basic out%0d: got %0d expected %0d", k, obs_all[k], exp_all[k]);
            end
        end
        n_tests++;
        if (seg_cnt !== 4'd5 || seg_err !== 1'b0 || valid_cnt != 1) begin
            n_fail++;
            $display("FAIL basic status: got cnt=%0d err=%0b pulses=%0d expected 5 0 1",
                     seg_cnt, seg_err, valid_cnt);
        end
    endtask

    task automatic test_narrow_run();
        bars.delete();
        add_base();
        add_bar(400, 401, 100, 10, 1'b1, 1'b0);
        run_frame();
        exp_all = '{12'd60, 12'd105, 12'd175, 12'd245, 12'd315, 12'd360,
                    12'd70, 12'd140, 12'd210, 12'd280, 12'd350};
        for (int k = 0; k < 11; k++) begin
            n_tests++;
            if (obs_all[k] !== exp_all[k]) begin
                n_fail++;
                $display("FAIL narrow out%0d: got %0d expected %0d", k, obs_all[k], exp_all[k]);
            end
        end
        n_tests++;
        if (seg_cnt !== 4'd5 || seg_err !== 1'b0 || valid_cnt != 1) begin
            n_fail++;
            $display("FAIL narrow status: got cnt=%0d err=%0b pulses=%0d expected 5 0 1",
                     seg_cnt, seg_err, valid_cnt);
        end
    endtask

    task automatic test_min_width();
        bars.delete();
        add_bar(60,  80,  100, 10, 1'b1, 1'b0);
        add_bar(130, 150, 100, 10, 1'b1, 1'b0);
        add_bar(200, 202, 100, 10, 1'b1, 1'b0);
        add_bar(270, 290, 100, 10, 1'b1, 1'b0);
        add_bar(340, 360, 100, 10, 1'b1, 1'b0);
        run_frame();
        exp_all = '{12'd60, 12'd105, 12'd175, 12'd236, 12'd315, 12'd360,
                    12'd70, 12'd140, 12'd201, 12'd280, 12'd350};
        for (int k = 0; k < 11; k++) begin
            n_tests++;
            if (obs_all[k] !== exp_all[k]) begin
                n_fail++;
                $display("FAIL minw out%0d: got %0d expected %0d", k, obs_all[k], exp_all[k]);
            end
        end
        n_tests++;
        if (seg_cnt !== 4'd5 || seg_err !== 1'b0 || valid_cnt != 1) begin
            n_fail++;
            $display("FAIL minw status: got cnt=%0d err=%0b pulses=%0d expected 5 0 1",
                     seg_cnt, seg_err, valid_cnt);
        end
    endtask

    task automatic test_threshold();
        // One pixel between bars: below threshold, not ink
        bars.delete();
        add_base();
        add_bar(110, 110, 100, 1, 1'b1, 1'b0);
        run_frame();
        exp_all = '{12'd60, 12'd105, 12'd175, 12'd245, 12'd315, 12'd360,
                    12'd70, 12'd140, 12'd210, 12'd280, 12'd350};
        for (int k = 0; k < 11; k++) begin
            n_tests++;
            if (obs_all[k] !== exp_all[k]) begin
                n_fail++;
                $display("FAIL thresh1 out%0d: got %0d expected %0d", k, obs_all[k], exp_all[k]);
            end
        end
        // Two pixels next to the first bar: exactly at threshold, widens it
        bars.delete();
        add_base();
        add_bar(59, 59, 100, 2, 1'b1, 1'b0);
        run_frame();
        exp_all = '{12'd59, 12'd105, 12'd175, 12'd245, 12'd315, 12'd360,
                    12'd69, 12'd140, 12'd210, 12'd280, 12'd350};
        for (int k = 0; k < 11; k++) begin
            n_tests++;
            if (obs_all[k] !== exp_all[k]) begin
                n_fail++;
                $display("FAIL thresh2 out%0d: got %0d expected %0d", k, obs_all[k], exp_all[k]);
            end
        end
        n_tests++;
        if (seg_cnt !== 4'd5 || valid_cnt != 1) begin
            n_fail++;
            $display("FAIL thresh2 status: got cnt=%0d pulses=%0d expected 5 1", seg_cnt, valid_cnt);
        end
    endtask

    task automatic test_missing_run();
        bars.delete();
        add_bar(60,  80,  100, 10, 1'b1, 1'b0);
        add_bar(130, 150, 100, 10, 1'b1, 1'b0);
        add_bar(200, 220, 100, 10, 1'b1, 1'b0);
        add_bar(340, 360, 100, 10, 1'b1, 1'b0);
        run_frame();
        exp_all = '{12'd59, 12'd105, 12'd175, 12'd245, 12'd315, 12'd360,
                    12'd69, 12'd140, 12'd210, 12'd280, 12'd350};
        for (int k = 0; k < 11; k++) begin
            n_tests++;
            if (obs_all[k] !== exp_all[k]) begin
                n_fail++;
                $display("FAIL missing hold out%0d: got %0d expected %0d", k, obs_all[k], exp_all[k]);
            end
        end
        n_tests++;
        if (seg_cnt !== 4'd4 || seg_err !== 1'b1 || valid_cnt != 0) begin
            n_fail++;
            $display("FAIL missing status: got cnt=%0d err=%0b pulses=%0d expected 4 1 0",
                     seg_cnt, seg_err, valid_cnt);
        end
    endtask

    task automatic test_clip();
        bars.delete();
        add_bar(40,  80,  100, 10, 1'b1, 1'b0);
        add_bar(130, 150, 100, 10, 1'b1, 1'b0);
        add_bar(200, 220, 100, 10, 1'b1, 1'b0);
        add_bar(270, 290, 100, 10, 1'b1, 1'b0);
        add_bar(420, 440, 100, 10, 1'b1, 1'b0);
        run_frame();
        exp_all = '{12'd50, 12'd105, 12'd175, 12'd245, 12'd355, 12'd430,
                    12'd65, 12'd140, 12'd210, 12'd280, 12'd425};
        for (int k = 0; k < 11; k++) begin
            n_tests++;
            if (obs_all[k] !== exp_all[k]) begin
                n_fail++;
                $display("FAIL clip out%0d: got %0d expected %0d", k, obs_all[k], exp_all[k]);
            end
        end
        n_tests++;
        if (seg_cnt !== 4'd5 || seg_err !== 1'b0 || valid_cnt != 1) begin
            n_fail++;
            $display("FAIL clip status: got cnt=%0d err=%0b pulses=%0d expected 5 0 1",
                     seg_cnt, seg_err, valid_cnt);
        end
    endtask

    task automatic test_extra_run();
        bars.delete();
        add_base();
        add_bar(380, 385, 100, 10, 1'b1, 1'b0);
        run_frame();
        n_tests++;
        if (seg_cnt !== 4'd6 || seg_err !== 1'b1 || valid_cnt != 0) begin
            n_fail++;
            $display("FAIL extra status: got cnt=%0d err=%0b pulses=%0d expected 6 1 0",
                     seg_cnt, seg_err, valid_cnt);
        end
        n_tests++;
        if (Partition_line6 !== 12'd430 || char1_middle !== 12'd65) begin
            n_fail++;
            $display("FAIL extra hold: got line6=%0d mid1=%0d expected 430 65",
                     Partition_line6, char1_middle);
        end
    endtask

    task automatic test_inverted_plate();
        edge_left  = 12'd430;
        edge_right = 12'd50;
        bars.delete();
        add_base();
        run_frame();
        n_tests++;
        if (seg_cnt !== 4'd0 || seg_err !== 1'b1 || valid_cnt != 0) begin
            n_fail++;
            $display("FAIL inverted status: got cnt=%0d err=%0b pulses=%0d expected 0 1 0",
                     seg_cnt, seg_err, valid_cnt);
        end
        edge_left  = 12'd50;
        edge_right = 12'd430;
    endtask

    task automatic test_back_to_back();
        bars.delete();
        add_base();
        run_frame();
        n_tests++;
        if (seg_cnt !== 4'd5 || seg_err !== 1'b0 || valid_cnt != 1) begin
            n_fail++;
            $display("FAIL b2b first: got cnt=%0d err=%0b pulses=%0d expected 5 0 1",
                     seg_cnt, seg_err, valid_cnt);
        end
        bars.delete();
        run_frame();
        n_tests++;
        if (seg_cnt !== 4'd0 || seg_err !== 1'b1 || valid_cnt != 0) begin
            n_fail++;
            $display("FAIL b2b empty: got cnt=%0d err=%0b pulses=%0d expected 0 1 0",
                     seg_cnt, seg_err, valid_cnt);
        end
        bars.delete();
        add_base();
        run_frame();
        exp_all = '{12'd60, 12'd105, 12'd175, 12'd245, 12'd315, 12'd360,
                    12'd70, 12'd140, 12'd210, 12'd280, 12'd350};
        for (int k = 0; k < 11; k++) begin
            n_tests++;
            if (obs_all[k] !== exp_all[k]) begin
                n_fail++;
                $display("FAIL b2b third out%0d: got %0d expected %0d", k, obs_all[k], exp_all[k]);
            end
        end
        n_tests++;
        if (seg_cnt !== 4'd5 || seg_err !== 1'b0 || valid_cnt != 1) begin
            n_fail++;
            $display("FAIL b2b third status: got cnt=%0d err=%0b pulses=%0d expected 5 0 1",
                     seg_cnt, seg_err, valid_cnt);
        end
    endtask

    task automatic test_reset_mid_scan();
        bars.delete();
        add_base();
        drive_bars();
        pulse_vs();
        idle(100);
        rst = 1'b1;
        @(negedge clk);
        for (int k = 0; k < 11; k++) begin
            n_tests++;
            if (obs_all[k] !== 12'd0) begin
                n_fail++;
                $display("FAIL midrst out%0d: got %0d expected 0", k, obs_all[k]);
            end
        end
        n_tests++;
        if ({seg_cnt, seg_valid, seg_err} !== 6'd0) begin
            n_fail++;
            $display("FAIL midrst status: got cnt=%0d valid=%0b err=%0b expected all 0",
                     seg_cnt, seg_valid, seg_err);
        end
        idle(3);
        rst = 1'b0;
        idle(2);
        run_frame();
        run_frame();
        exp_all = '{12'd60, 12'd105, 12'd175, 12'd245, 12'd315, 12'd360,
                    12'd70, 12'd140, 12'd210, 12'd280, 12'd350};
        for (int k = 0; k < 11; k++) begin
            n_tests++;
            if (obs_all[k] !== exp_all[k]) begin
                n_fail++;
                $display("FAIL midrst recover out%0d: got %0d expected %0d", k, obs_all[k], exp_all[k]);
            end
        end
        n_tests++;
        if (seg_cnt !== 4'd5 || seg_err !== 1'b0 || valid_cnt != 1) begin
            n_fail++;
            $display("FAIL midrst recover status: got cnt=%0d err=%0b pulses=%0d expected 5 0 1",
                     seg_cnt, seg_err, valid_cnt);
        end
    endtask

    initial begin
        rst        = 1'b1;
        i_vs       = 1'b0;
        i_de       = 1'b0;
        i_bit      = 1'b0;
        x          = '0;
        y          = '0;
        edge_left  = 12'd50;
        edge_right = 12'd430;
        edge_up    = 12'd70;
        edge_down  = 12'd200;
        test_reset();
        test_basic();
        test_narrow_run();
        test_min_width();
        test_threshold();
        test_missing_run();
        test_clip();
        test_extra_run();
        test_inverted_plate();
        test_back_to_back();
        test_reset_mid_scan();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
